wb_commit_stage: RTL
====================

WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning the number of instructions retired per cycle (1..4).
REQ-002 SHALL have parameter XLEN, default 32, meaning the datapath width.
REQ-003 SHALL have port clk, input, 1, clock; reset rst, synchronous, active-low; clock clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, which discards stage contents and pending loads.
REQ-006 SHALL have port mem_valid_i, input, 1, meaning the MEM group is valid; pba_ok_i, input, 1, meaning the downstream may change; wb_allowin_o, output, 1, meaning the stage accepts a group.
REQ-007 SHALL have the following per-lane inputs, packed with lane 0 at the LSBs: mem_wnum_i (LANES*5); mem_pc_i (LANES*XLEN); mem_res_i (LANES*XLEN); mem_rt_i (LANES*XLEN); mem_memreq_i (LANES); mem_align_i (LANES*2); mem_loadsel_i (LANES*11).
REQ-008 SHALL have port data_ok_i, input, 1, and port data_rdata_i, input, XLEN, carrying load responses returned in lane order, at most one per cycle.
REQ-009 SHALL have outputs wb_wen_o (LANES), wb_wnum_o (LANES*5), wb_wdata_o (LANES*XLEN), wb_fwd_o (LANES*XLEN) and wb_busy_o (1).
REQ-010 SHALL have outputs dbg_pc_o (LANES*XLEN), dbg_wen_o (LANES*4), dbg_wnum_o (LANES*5) and dbg_wdata_o (LANES*XLEN).

Function
REQ-011 SHALL use the FSM states EMPTY, WAIT and READY.
REQ-012 SHALL set wb_allowin_o = (state!=WAIT) && pba_ok_i.
REQ-013 SHALL capture all lane inputs when wb_allowin_o && mem_valid_i; next state is WAIT if any mem_memreq_i bit is set, else READY.
REQ-014 SHALL enter EMPTY when wb_allowin_o && !mem_valid_i.
REQ-015 SHALL, in WAIT on data_ok_i, store data_rdata_i into the lowest-index load lane not yet filled; when the last load lane is filled, the next state is READY.
REQ-016 SHALL assert wb_wen_o[i] only when state==READY && pba_ok_i && wnum[i]!=0 && no higher lane j>i in the group has wnum[j]==wnum[i].
REQ-017 SHALL compute wb_wdata_o[i] as mem_res for non-load lanes; for load lanes it SHALL apply load extraction from loadsel/align: LB/LBU byte select with sign extension; LH/LHU half select; LW full word; LWL L0/L1/L2 and LWR R1/R2/R3 merging with mem_rt.
REQ-018 SHALL drive wb_fwd_o[i] = wb_wdata_o[i], and wb_busy_o = (state==WAIT); the ID stage stalls dependent operands while wb_busy_o is high.
REQ-019 SHALL, on flush_i, enter EMPTY with all wen at 0 in the same cycle; flush_i takes priority over capture in the same cycle.
REQ-020 SHALL, when flush_i occurs in WAIT with k responses outstanding, load drop_cnt=k and ignore the next k data_ok_i pulses; drop_cnt is sized clog2(LANES+1).
REQ-021 SHALL give a data_ok_i pulse arriving while drop_cnt>0 zero effect on lane data, and it SHALL decrement drop_cnt even if a new group has been captured.
REQ-022 SHALL ignore data_ok_i in EMPTY/READY when drop_cnt==0, and SHALL NOT flag an error for it.

Reset
REQ-023 SHALL, on !rst, set state=EMPTY, drop_cnt=0, all captured registers to 0, wb_wen_o=0, wb_busy_o=0, all dbg_* outputs to 0, and wb_allowin_o=pba_ok_i.

Configuration
REQ-024 SHALL, with WB_DEBUG_TRACE_EN defined, register dbg_* one cycle after commit: dbg_wen_o[i]={4{wb_wen_o[i]}}, with dbg_pc/wnum/wdata copied from lane i.
REQ-025 SHALL, without WB_DEBUG_TRACE_EN, tie dbg_* to constant 0 and generate no trace registers.

Structure
REQ-026 SHALL place the loadsel one-hot bit indices (LB,LBU,LH,LHU,LW,L0,L1,L2,R1,R2,R3), the FSM state encoding and the GPR index width in shared package wb_pkg.
REQ-027 SHALL implement per-lane extraction as combinational sub-module wb_load_align, instantiated LANES times.

Verification
REQ-028 SHALL cover: LANES=2, lane0 ADD r3=0x5, lane1 ADD r4=0x7, no loads -> READY next cycle, wen=2'b11, wdata={0x7,0x5}.
REQ-029 SHALL cover: lane0 LB align=2, data_rdata=0x00800000 -> wdata0=0xFFFFFF80; with LBU instead -> wdata0=0x00000080.
REQ-030 SHALL cover: both lanes write r5 (0x1, then 0x2) -> wen=2'b10, and r5 ends as 0x2.
REQ-031 SHALL cover: two loads, data_ok_i arrives on cycles 3 and 6 -> wb_busy_o=1 through cycle 6, allowin=0, READY on cycle 7.
REQ-032 SHALL cover: flush_i in WAIT with 2 loads outstanding, new group captured, then 3 data_ok_i pulses (0xA,0xB,0xC) -> 0xA and 0xB are dropped, and the new load lane receives 0xC.
REQ-033 SHALL cover: rst low mid-WAIT -> EMPTY next cycle, wen=0, dbg_wen_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage.
// Load-select bit positions, FSM encoding and GPR index width.
package wb_pkg;

  localparam int GPR_W = 5;
  localparam int LS_W  = 11;

  localparam int LS_LB  = 0;
  localparam int LS_LBU = 1;
  localparam int LS_LH  = 2;
  localparam int LS_LHU = 3;
  localparam int LS_LW  = 4;
  localparam int LS_L0  = 5;
  localparam int LS_L1  = 6;
  localparam int LS_L2  = 7;
  localparam int LS_R1  = 8;
  localparam int LS_R2  = 9;
  localparam int LS_R3  = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Per-lane load data extraction: byte/half select, sign
// extension and unaligned-word merging with the old rt value.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_load,
  input  logic [1:0]      i_align,
  input  logic [LS_W-1:0] i_loadsel,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_rt,
  input  logic [XLEN-1:0] i_res,
  output logic [XLEN-1:0] o_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;
  logic [31:0] w_rt;

  assign w_byte = i_data[{i_align, 3'b000} +: 8];
  assign w_half = i_data[{i_align[1], 4'b0000} +: 16];
  assign w_word = i_data[31:0];
  assign w_rt   = i_rt[31:0];

  // select the result: ALU value unless this lane is a load
  always_comb begin
    o_wdata = i_res;
    if (i_load) begin
      unique case (1'b1)
        i_loadsel[LS_LB]:
          o_wdata = XLEN'($signed(w_byte));
        i_loadsel[LS_LBU]:
          o_wdata = XLEN'(w_byte);
        i_loadsel[LS_LH]:
          o_wdata = XLEN'($signed(w_half));
        i_loadsel[LS_LHU]:
          o_wdata = XLEN'(w_half);
        i_loadsel[LS_LW]:
          o_wdata = XLEN'($signed(w_word));
        i_loadsel[LS_L0]:
          o_wdata = XLEN'($signed(
            {w_word[7:0], w_rt[23:0]}));
        i_loadsel[LS_L1]:
          o_wdata = XLEN'($signed(
            {w_word[15:0], w_rt[15:0]}));
        i_loadsel[LS_L2]:
          o_wdata = XLEN'($signed(
            {w_word[23:0], w_rt[7:0]}));
        i_loadsel[LS_R1]:
          o_wdata = XLEN'($signed(
            {w_rt[31:24], w_word[31:8]}));
        i_loadsel[LS_R2]:
          o_wdata = XLEN'($signed(
            {w_rt[31:16], w_word[31:16]}));
        i_loadsel[LS_R3]:
          o_wdata = XLEN'($signed(
            {w_rt[31:8], w_word[31:24]}));
        default:
          o_wdata = i_res;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane writeback/commit stage with in-order load returns.
// Optional retire trace on dbg_* when WB_DEBUG_TRACE_EN is defined.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     mem_valid_i,
  input  logic                     pba_ok_i,
  output logic                     wb_allowin_o,
  input  logic [LANES*GPR_W-1:0]   mem_wnum_i,
  input  logic [LANES*XLEN-1:0]    mem_pc_i,
  input  logic [LANES*XLEN-1:0]    mem_res_i,
  input  logic [LANES*XLEN-1:0]    mem_rt_i,
  input  logic [LANES-1:0]         mem_memreq_i,
  input  logic [LANES*2-1:0]       mem_align_i,
  input  logic [LANES*LS_W-1:0]    mem_loadsel_i,
  input  logic                     data_ok_i,
  input  logic [XLEN-1:0]          data_rdata_i,
  output logic [LANES-1:0]         wb_wen_o,
  output logic [LANES*GPR_W-1:0]   wb_wnum_o,
  output logic [LANES*XLEN-1:0]    wb_wdata_o,
  output logic [LANES*XLEN-1:0]    wb_fwd_o,
  output logic                     wb_busy_o,
  output logic [LANES*XLEN-1:0]    dbg_pc_o,
  output logic [LANES*4-1:0]       dbg_wen_o,
  output logic [LANES*GPR_W-1:0]   dbg_wnum_o,
  output logic [LANES*XLEN-1:0]    dbg_wdata_o
);

  localparam int DW = $clog2(LANES + 1);

  wb_state_t                r_state;
  logic [DW-1:0]            r_drop;
  logic [LANES*GPR_W-1:0]   r_wnum;
  logic [LANES*XLEN-1:0]    r_pc;
  logic [LANES*XLEN-1:0]    r_res;
  logic [LANES*XLEN-1:0]    r_rt;
  logic [LANES*XLEN-1:0]    r_ldata;
  logic [LANES-1:0]         r_memreq;
  logic [LANES-1:0]         r_pend;
  logic [LANES*2-1:0]       r_align;
  logic [LANES*LS_W-1:0]    r_loadsel;

  logic                     w_allowin;
  logic                     w_commit;
  logic                     w_dok_drop;
  logic                     w_dok_fill;
  logic [LANES-1:0]         w_fill_oh;
  logic [LANES-1:0]         w_pend_nxt;
  logic [DW-1:0]            w_drop_dec;
  logic [DW-1:0]            w_outst;
  logic [DW:0]              w_drop_sum;
  logic [DW-1:0]            w_drop_flush;
  logic [LANES-1:0]         w_dup;
  logic [LANES-1:0]         w_wen;
  logic [LANES*XLEN-1:0]    w_wdata;

  assign w_allowin  = (r_state != WAIT) && pba_ok_i;
  assign w_commit   = (r_state == READY) && pba_ok_i
                      && !flush_i;
  assign w_dok_drop = data_ok_i && (r_drop != '0);
  assign w_dok_fill = data_ok_i && (r_drop == '0)
                      && (r_state == WAIT);
  assign w_fill_oh  = r_pend & (~r_pend + LANES'(1));
  assign w_pend_nxt = w_dok_fill ? (r_pend & ~w_fill_oh)
                                 : r_pend;
  assign w_drop_dec = r_drop - DW'(w_dok_drop);

  // responses still owed by memory after this cycle
  always_comb begin
    w_outst = '0;
    for (int i = 0; i < LANES; i++) begin
      w_outst = w_outst + DW'(w_pend_nxt[i]);
    end
  end

  assign w_drop_sum   = {1'b0, w_drop_dec} + {1'b0, w_outst};
  assign w_drop_flush = w_drop_sum[DW] ? '1
                                       : w_drop_sum[DW-1:0];

  // state, group capture, load fill and stale-response drop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= EMPTY;
      r_drop    <= '0;
      r_wnum    <= '0;
      r_pc      <= '0;
      r_res     <= '0;
      r_rt      <= '0;
      r_ldata   <= '0;
      r_memreq  <= '0;
      r_pend    <= '0;
      r_align   <= '0;
      r_loadsel <= '0;
    end else if (flush_i) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_drop  <= (r_state == WAIT) ? w_drop_flush
                                   : w_drop_dec;
    end else begin
      r_drop <= w_drop_dec;
      if (w_allowin && mem_valid_i) begin
        r_wnum    <= mem_wnum_i;
        r_pc      <= mem_pc_i;
        r_res     <= mem_res_i;
        r_rt      <= mem_rt_i;
        r_memreq  <= mem_memreq_i;
        r_pend    <= mem_memreq_i;
        r_align   <= mem_align_i;
        r_loadsel <= mem_loadsel_i;
        r_ldata   <= '0;
        r_state   <= (|mem_memreq_i) ? WAIT : READY;
      end else if (w_allowin) begin
        r_state <= EMPTY;
      end else if (w_dok_fill) begin
        for (int i = 0; i < LANES; i++) begin
          if (w_fill_oh[i]) begin
            r_ldata[i*XLEN +: XLEN] <= data_rdata_i;
          end
        end
        r_pend <= w_pend_nxt;
        if (w_pend_nxt == '0) begin
          r_state <= READY;
        end
      end
    end
  end

  // a later lane writing the same register wins
  always_comb begin
    w_dup = '0;
    w_wen = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (r_wnum[j*GPR_W +: GPR_W]
            == r_wnum[i*GPR_W +: GPR_W]) begin
          w_dup[i] = 1'b1;
        end
      end
      w_wen[i] = w_commit
                 && (r_wnum[i*GPR_W +: GPR_W] != '0)
                 && !w_dup[i];
    end
  end

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    wb_load_align #(
      .XLEN (XLEN)
    ) u_align (
      .i_load    (r_memreq[g]),
      .i_align   (r_align[g*2 +: 2]),
      .i_loadsel (r_loadsel[g*LS_W +: LS_W]),
      .i_data    (r_ldata[g*XLEN +: XLEN]),
      .i_rt      (r_rt[g*XLEN +: XLEN]),
      .i_res     (r_res[g*XLEN +: XLEN]),
      .o_wdata   (w_wdata[g*XLEN +: XLEN])
    );
  end

  assign wb_allowin_o = w_allowin;
  assign wb_wen_o     = w_wen;
  assign wb_wnum_o    = r_wnum;
  assign wb_wdata_o   = w_wdata;
  assign wb_fwd_o     = w_wdata;
  assign wb_busy_o    = (r_state == WAIT);

`ifdef WB_DEBUG_TRACE_EN
  logic [LANES*XLEN-1:0]  r_dbg_pc;
  logic [LANES*4-1:0]     r_dbg_wen;
  logic [LANES*GPR_W-1:0] r_dbg_wnum;
  logic [LANES*XLEN-1:0]  r_dbg_wdata;

  // trace each retired group one cycle after commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbg_pc    <= '0;
      r_dbg_wen   <= '0;
      r_dbg_wnum  <= '0;
      r_dbg_wdata <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        r_dbg_wen[i*4 +: 4] <= {4{w_wen[i]}};
      end
      r_dbg_pc    <= r_pc;
      r_dbg_wnum  <= r_wnum;
      r_dbg_wdata <= w_wdata;
    end
  end

  assign dbg_pc_o    = r_dbg_pc;
  assign dbg_wen_o   = r_dbg_wen;
  assign dbg_wnum_o  = r_dbg_wnum;
  assign dbg_wdata_o = r_dbg_wdata;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^r_pc;

  assign dbg_pc_o    = '0;
  assign dbg_wen_o   = '0;
  assign dbg_wnum_o  = '0;
  assign dbg_wdata_o = '0;
`endif

endmodule
